// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM with retired-instruction counter
module multicycle_control #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_w,
  output logic               iord,
  output logic               mem_r,
  output logic               mem_w,
  output logic               ir_w,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_w,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_ctl,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_ILLEGAL   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [3:0] next_state;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       retire;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_ILLEGAL;
    case (state)
      S_RESET:     next_state = S_FETCH;
      S_FETCH:     next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = S_R_EXEC;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state = S_MEM_WB;
      S_R_EXEC:    next_state = funct_ok ? S_R_WB : S_ILLEGAL;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      default:     next_state = S_ILLEGAL;
    endcase
  end

  assign retire = (state == S_MEM_WB) || (state == S_MEM_WRITE) || (state == S_R_WB) ||
                  (state == S_BRANCH) || (state == S_JUMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // ILLEGAL is absorbing, so decoding the flag from state keeps it sticky until reset.
  assign illegal = (state == S_ILLEGAL);

  always_comb begin
    pc_w       = 1'b0;
    iord       = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = ALU_AND;
    pc_src     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_r     = 1'b1;
        ir_w      = 1'b1;
        alu_src_b = 2'b01;
        alu_ctl   = ALU_ADD;
        pc_w      = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctl   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctl   = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_r = 1'b1;
        iord  = 1'b1;
      end
      S_MEM_WB: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_w = 1'b1;
        iord  = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctl   = funct_alu;
      end
      S_R_WB: begin
        reg_w   = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_src    = 2'b01;
        pc_w      = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_w   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
